// File: rtl/dmx8_seq.sv
// -----------------------------------------------------------------------------
// dmx8_seq : registered 1-to-8 demultiplexer / distributor
//
// Routes one WIDTH-bit word into one of eight held output lanes. The lane is
// picked by an explicit 3-bit select (addressed mode, mode=0) or by an
// internal wrap-around pointer (sequential mode, mode=1). It tracks which lanes
// hold data and pulses frame_done after the eighth sequential write.
//
// Optional build macro: DMX8_PARITY_EN adds output y_par (even parity per lane).
//
// Ports:
//   clk        rising-edge clock
//   reset_n    synchronous reset, active-low
//   d_in       data word to distribute
//   valid_in   write strobe
//   s          lane select (addressed mode only)
//   mode       0 = addressed (lane = s), 1 = sequential (lane = ptr)
//   clear      synchronous frame clear (lane_valid/ptr only, data kept)
//   y          packed lanes, lane k is y[k*WIDTH +: WIDTH]
//   lane_valid bit k set once lane k is written since reset/clear
//   ptr        current sequential pointer
//   all_valid  all eight lanes valid
//   frame_done one-cycle pulse after a write with ptr==7 in sequential mode
//   y_par      (DMX8_PARITY_EN only) XOR reduction of the word held in lane k
//
// Handshake: valid_in is a one-sided strobe with no ready; the block accepts
// a word on every rising edge where valid_in=1, clear=0 and reset_n=1. There
// is no back-pressure, so a strobed word is never stalled.
// -----------------------------------------------------------------------------
module dmx8_seq #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [WIDTH-1:0]   d_in,
    input  logic               valid_in,
    input  logic [2:0]         s,
    input  logic               mode,
    input  logic               clear,
    output logic [8*WIDTH-1:0] y,
    output logic [7:0]         lane_valid,
    output logic [2:0]         ptr,
    output logic               all_valid,
    output logic               frame_done
`ifdef DMX8_PARITY_EN
    ,
    output logic [7:0]         y_par
`endif
);

    logic [WIDTH-1:0] lanes [8];
    logic [2:0]       lane;

    // s and mode only matter when a write actually happens.
    assign lane = mode ? ptr : s;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < 8; k++) begin
                lanes[k] <= '0;
            end
            lane_valid <= '0;
            ptr        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (clear) begin
                // Clear drops any simultaneous write; lane data is retained.
                lane_valid <= '0;
                ptr        <= '0;
            end else if (valid_in) begin
                for (int k = 0; k < 8; k++) begin
                    if (lane == 3'(k)) begin
                        lanes[k] <= d_in;
                    end
                end
                lane_valid[lane] <= 1'b1;
                if (mode) begin
                    ptr        <= ptr + 3'd1;
                    frame_done <= (ptr == 3'd7);
                end
            end
        end
    end

`ifdef DMX8_PARITY_EN
    // Parity follows the lane data: written on the same edge, kept on clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            y_par <= '0;
        end else if (!clear && valid_in) begin
            y_par[lane] <= ^d_in;
        end
    end
`endif

    for (genvar g = 0; g < 8; g++) begin : g_pack
        assign y[g*WIDTH +: WIDTH] = lanes[g];
    end

    assign all_valid = &lane_valid;

endmodule

// File: tb/tb_dmx8_seq.sv
module tb_dmx8_seq;

    localparam int WIDTH = 4;

    // ---------------- clock / reset / DUT ----------------
    logic               clk = 1'b0;
    logic               reset_n;
    logic [WIDTH-1:0]   d_in;
    logic               valid_in;
    logic [2:0]         s;
    logic               mode;
    logic               clear;
    logic [8*WIDTH-1:0] y;
    logic [7:0]         lane_valid;
    logic [2:0]         ptr;
    logic               all_valid;
    logic               frame_done;
`ifdef DMX8_PARITY_EN
    logic [7:0]         y_par;
`endif

    always #5 clk = ~clk;

    dmx8_seq #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .d_in       (d_in),
        .valid_in   (valid_in),
        .s          (s),
        .mode       (mode),
        .clear      (clear),
        .y          (y),
        .lane_valid (lane_valid),
        .ptr        (ptr),
        .all_valid  (all_valid),
        .frame_done (frame_done)
`ifdef DMX8_PARITY_EN
        ,
        .y_par      (y_par)
`endif
    );

    // ---------------- reference model ----------------
    int m_lane  [8];
    int m_valid [8];
    int m_par   [8];
    int m_ptr;
    int m_done;

    int n_vec  = 0;
    int n_fail = 0;

    function automatic int parity_of(int v);
        int p = 0;
        for (int b = 0; b < WIDTH; b++) p = p ^ ((v >> b) & 1);
        return p;
    endfunction

    task automatic model_edge(input int rst_n, input int v, input int dv,
                              input int sel, input int md, input int clr);
        int tgt;
        if (rst_n == 0) begin
            for (int k = 0; k < 8; k++) begin
                m_lane[k] = 0; m_valid[k] = 0; m_par[k] = 0;
            end
            m_ptr = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (clr != 0) begin
                for (int k = 0; k < 8; k++) m_valid[k] = 0;
                m_ptr = 0;
            end else if (v != 0) begin
                tgt = (md != 0) ? m_ptr : sel;
                m_lane[tgt]  = dv;
                m_valid[tgt] = 1;
                m_par[tgt]   = parity_of(dv);
                if (md != 0) begin
                    m_done = (m_ptr == 7) ? 1 : 0;
                    m_ptr  = (m_ptr + 1) % 8;
                end
            end
        end
    endtask

    // ---------------- comparison ----------------
    task automatic cmp(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string step);
        int exp_lv;
        int exp_all;
        exp_lv = 0;
        for (int k = 0; k < 8; k++) begin
            cmp($sformatf("%s lane%0d", step, k), int'(y[k*WIDTH +: WIDTH]), m_lane[k]);
            exp_lv = exp_lv | (m_valid[k] << k);
        end
        exp_all = (exp_lv == 255) ? 1 : 0;
        cmp({step, " lane_valid"}, int'(lane_valid), exp_lv);
        cmp({step, " ptr"},        int'(ptr),        m_ptr);
        cmp({step, " all_valid"},  int'(all_valid),  exp_all);
        cmp({step, " frame_done"}, int'(frame_done), m_done);
`ifdef DMX8_PARITY_EN
        for (int k = 0; k < 8; k++)
            cmp($sformatf("%s y_par%0d", step, k), int'(y_par[k]), m_par[k]);
`endif
    endtask

    // ---------------- driver ----------------
    // Drive on the falling edge, update the model at the rising edge, check
    // on the following falling edge.
    task automatic apply(input string step, input int rst_n, input int v,
                         input int dv, input int sel, input int md, input int clr);
        reset_n  = 1'(rst_n);
        valid_in = 1'(v);
        d_in     = WIDTH'(dv);
        s        = 3'(sel);
        mode     = 1'(md);
        clear    = 1'(clr);
        @(posedge clk);
        model_edge(rst_n, v, dv, sel, md, clr);
        @(negedge clk);
        check_all(step);
    endtask

    task automatic idle(input string step);
        apply(step, 1, 0, 0, 0, 0, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset with a live strobe must still zero everything.
        apply("rst0", 0, 1, 15, 3, 1, 0);
        apply("rst1", 0, 1, 15, 6, 0, 0);
        idle("post_rst");
        cmp("post_rst lv_zero", int'(lane_valid), 0);

        // Addressed mode
        apply("addr5", 1, 1, 'hA, 5, 0, 0);
        apply("addr0", 1, 1, 'h3, 0, 0, 0);
        cmp("addr lane_valid_21", int'(lane_valid), 'h21);
        cmp("addr lane5_A", int'(y[5*WIDTH +: WIDTH]), 'hA);

        // Sequential full frame
        for (int k = 0; k < 8; k++)
            apply($sformatf("seq%0d", k), 1, 1, k, 7 - k, 1, 0);
        cmp("seq frame_done_pulse", int'(frame_done), 1);
        cmp("seq all_valid", int'(all_valid), 1);
        idle("seq_after");
        cmp("seq frame_done_drop", int'(frame_done), 0);

        // Clear priority mid-frame (ptr=3)
        apply("clr_pre", 1, 1, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++)
            apply($sformatf("clrfill%0d", k), 1, 1, 8 + k, 0, 1, 0);
        cmp("clr ptr3", int'(ptr), 3);
        apply("clr_hit", 1, 1, 'hC, 0, 1, 1);
        cmp("clr lane3_kept", int'(y[3*WIDTH +: WIDTH]), 3);
        apply("clr_next", 1, 1, 'hE, 0, 1, 0);
        cmp("clr next_lane0", int'(y[0 +: WIDTH]), 'hE);

        // Mode switch keeps ptr
        apply("ms_clr", 1, 0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++)
            apply($sformatf("msfill%0d", k), 1, 1, 1 + k, 0, 1, 0);
        apply("ms_addr7", 1, 1, 9, 7, 0, 0);
        cmp("ms ptr_held", int'(ptr), 3);
        apply("ms_resume", 1, 1, 'hB, 0, 1, 0);
        cmp("ms lane3_B", int'(y[3*WIDTH +: WIDTH]), 'hB);

`ifdef DMX8_PARITY_EN
        apply("par_1011", 1, 1, 'b1011, 2, 0, 0);
        cmp("par lane2_one", int'(y_par[2]), 1);
        apply("par_1001", 1, 1, 'b1001, 2, 0, 0);
        cmp("par lane2_zero", int'(y_par[2]), 0);
        apply("par_1110", 1, 1, 'b1110, 4, 0, 0);
        apply("par_clr", 1, 0, 0, 0, 0, 1);
        cmp("par kept_on_clear", int'(y_par[4]), 1);
`endif

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            int r_rst, r_clr;
            r_rst = ($urandom_range(0, 99) < 2)  ? 0 : 1;
            r_clr = ($urandom_range(0, 99) < 5)  ? 1 : 0;
            apply($sformatf("rnd%0d", i), r_rst,
                  ($urandom_range(0, 99) < 70) ? 1 : 0,
                  int'($urandom_range(0, (1 << WIDTH) - 1)),
                  int'($urandom_range(0, 7)),
                  ($urandom_range(0, 99) < 60) ? 1 : 0,
                  r_clr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
